// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction register. It issues
// instruction-memory reads through an IDLE/REQ/DONE handshake and applies
// jump/branch redirects. A redirect that arrives while a fetch is in flight
// is held in a one-entry pending register and used at the next ack instead
// of pc+4. A fetch with no ack is aborted after TIMEOUT request cycles, and
// this sets a sticky fault flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        jump_flag,
    input  logic        branch_flag,
    input  logic        alu_zero,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] PEND_NONE   = 2'd0;
    localparam logic [1:0] PEND_JUMP   = 2'd1;
    localparam logic [1:0] PEND_BRANCH = 2'd2;
    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic [7:0]  wait_cnt_reg;
    logic        fault_reg;
    logic        imem_req_reg;
    logic        ir_valid_reg;
    logic        busy_reg;
    logic [1:0]  pend_type_reg;
    logic [29:0] pend_tgt_reg;

    logic        br_taken;
    logic        redirect_now;
    logic [1:0]  new_type;
    logic [29:0] new_tgt;
    logic [1:0]  eff_type;
    logic [29:0] eff_tgt;
    logic [31:0] jump_pc;
    logic [31:0] branch_pc;
    logic [31:0] ack_pc;

    assign br_taken     = branch_flag & alu_zero;
    assign redirect_now = jump_flag | br_taken;
    assign jump_pc      = {pc_reg[31:28], ir_reg[25:0], 2'b00};
    assign branch_pc    = {branch_target[31:2], 2'b00};

    // Incoming redirect encoded as a pending entry; jump beats a taken branch.
    // A jump stores the 26-bit field of the current ir, a branch stores the word address.
    assign new_type = jump_flag ? PEND_JUMP : (br_taken ? PEND_BRANCH : PEND_NONE);
    assign new_tgt  = jump_flag ? {4'b0000, ir_reg[25:0]} : branch_target[31:2];

    // A redirect that coincides with the ack is the newest one, so it overrides the pending entry.
    assign eff_type = redirect_now ? new_type : pend_type_reg;
    assign eff_tgt  = redirect_now ? new_tgt  : pend_tgt_reg;

    // Next PC at ack, in priority order: pending jump, pending branch, then sequential (wraps mod 2^32).
    always_comb begin
        ack_pc = pc_reg + 32'd4;
        if (eff_type == PEND_JUMP)
            ack_pc = {pc_reg[31:28], eff_tgt[25:0], 2'b00};
        else if (eff_type == PEND_BRANCH)
            ack_pc = {eff_tgt, 2'b00};
    end

    // Fetch FSM: one block holds all state and the registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            ir_reg        <= 32'h0;
            wait_cnt_reg  <= 8'h0;
            fault_reg     <= 1'b0;
            imem_req_reg  <= 1'b0;
            ir_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            pend_type_reg <= PEND_NONE;
            pend_tgt_reg  <= 30'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The redirect is applied in this cycle, so a fetch that starts now reads the redirected pc.
                    if (jump_flag)
                        pc_reg <= jump_pc;
                    else if (br_taken)
                        pc_reg <= branch_pc;
                    if (fetch_en && !fault_reg) begin
                        state_reg    <= REQ;
                        imem_req_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        wait_cnt_reg <= 8'h0;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        ir_reg        <= imem_rdata;
                        pc_reg        <= ack_pc;
                        pend_type_reg <= PEND_NONE;
                        wait_cnt_reg  <= 8'h0;
                        imem_req_reg  <= 1'b0;
                        ir_valid_reg  <= 1'b1;
                        state_reg     <= DONE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        // Abort: pc, ir and the pending entry keep their values.
                        wait_cnt_reg <= 8'h0;
                        imem_req_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        fault_reg    <= 1'b1;
                        state_reg    <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        if (redirect_now) begin
                            pend_type_reg <= new_type;
                            pend_tgt_reg  <= new_tgt;
                        end
                    end
                end
                DONE: begin
                    ir_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                    if (redirect_now) begin
                        pend_type_reg <= new_type;
                        pend_tgt_reg  <= new_tgt;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    imem_req_reg <= 1'b0;
                    ir_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_reg;
    assign imem_addr = pc_reg;
    assign ir        = ir_reg;
    assign opcode    = ir_reg[31:26];
    assign funct     = ir_reg[5:0];
    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign ir_valid  = ir_valid_reg;
    assign busy      = busy_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a table of fetch vectors plus hand-written
// sequences for redirects, wrap-around, reset and timeout. Each completed
// fetch pushes its expected {ir, pc} onto a scoreboard queue. A monitor pops
// the queue on every ir_valid pulse and compares against it.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        jump_flag = 1'b0;
    logic        branch_flag = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ir_valid;
    logic        busy;
    logic        fault;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .jump_flag(jump_flag),
        .branch_flag(branch_flag), .alu_zero(alu_zero), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .ir(ir), .opcode(opcode), .funct(funct), .pc(pc),
        .pc_plus4(pc_plus4), .ir_valid(ir_valid), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } sb_t;
    sb_t sb[$];

    // kind: 0 none, 1 taken branch in first REQ cycle, 2 not-taken branch,
    // 3 jump in first REQ cycle, 4 taken branch during DONE
    typedef struct {
        logic [31:0] rdata;
        int          waits;
        int          kind;
        logic [31:0] btgt;
        logic [31:0] exp_pc;
    } vec_t;

    logic [31:0] mpc = 32'h0;   // bench model of pc

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        jump_flag = 1'b0;
        branch_flag = 1'b0;
        alu_zero = 1'b0;
    endtask

    task automatic set_redirect(input int kind, input logic [31:0] btgt);
        branch_target = btgt;
        if (kind == 1 || kind == 4) begin branch_flag = 1'b1; alu_zero = 1'b1; end
        if (kind == 2) begin branch_flag = 1'b1; alu_zero = 1'b0; end
        if (kind == 3) jump_flag = 1'b1;
    endtask

    // One complete fetch from IDLE, starting at the model pc.
    task automatic do_fetch(input logic [31:0] rdata, input int waits, input int kind,
                            input logic [31:0] btgt, input logic [31:0] exp_pc);
        logic [31:0] r;
        r = rdata;
        sb.push_back('{ir: rdata, pc: exp_pc});
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        if (kind >= 1 && kind <= 3) set_redirect(kind, btgt);
        for (int w = 0; w < waits; w++) begin
            check("req_wait", {31'b0, imem_req}, 32'h1);
            check("addr_wait", imem_addr, mpc);
            tick();
            clear_redirect();
        end
        check("req_ack", {31'b0, imem_req}, 32'h1);
        check("addr_ack", imem_addr, mpc);
        imem_ack = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack = 1'b0;
        clear_redirect();
        check("ir_valid", {31'b0, ir_valid}, 32'h1);
        check("ir", ir, rdata);
        check("opcode", {26'b0, opcode}, {26'b0, r[31:26]});
        check("funct", {26'b0, funct}, {26'b0, r[5:0]});
        check("pc", pc, exp_pc);
        if (kind == 4) set_redirect(4, btgt);
        tick();
        clear_redirect();
        check("ir_valid_drop", {31'b0, ir_valid}, 32'h0);
        check("busy_idle", {31'b0, busy}, 32'h0);
        mpc = exp_pc;
    endtask

    // Scoreboard monitor: every ir_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && ir_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ir_valid", {31'b0, ir_valid}, 32'h0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_ir", ir, e.ir);
                check("sb_pc", pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{32'h2002_0005, 0, 0, 32'h0,         32'h0000_0004};
        tbl[1] = '{32'h0810_0000, 3, 0, 32'h0,         32'h0000_0008};
        tbl[2] = '{32'h1234_5678, 1, 1, 32'h0000_0103, 32'h0000_0100};
        tbl[3] = '{32'h0000_0020, 0, 2, 32'hDEAD_BEEF, 32'h0000_0104};
        tbl[4] = '{32'h0800_0040, 2, 3, 32'h0,         32'h0000_0080};
        tbl[5] = '{32'h0000_0000, 0, 0, 32'h0,         32'h0000_0084};

        // Reset state
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Table-driven fetches
        for (int i = 0; i < 6; i++)
            do_fetch(tbl[i].rdata, tbl[i].waits, tbl[i].kind, tbl[i].btgt, tbl[i].exp_pc);

        // IDLE redirects: not-taken branch holds pc, taken branch loads it
        set_redirect(2, 32'h0000_5000);
        tick();
        clear_redirect();
        check("idle_br_not_taken", pc, 32'h0000_0084);
        set_redirect(1, 32'h0040_0013);
        tick();
        clear_redirect();
        check("idle_br_taken", pc, 32'h0040_0010);
        mpc = 32'h0040_0010;
        do_fetch(32'h0810_0000, 0, 0, 32'h0, 32'h0040_0014);

        // Jump plus taken branch plus fetch_en in the same IDLE cycle
        jump_flag = 1'b1;
        set_redirect(1, 32'h1000_0000);
        fetch_en = 1'b1;
        sb.push_back('{ir: 32'h1111_2222, pc: 32'h0040_0004});
        tick();
        fetch_en = 1'b0;
        clear_redirect();
        check("jump_wins_pc", pc, 32'h0040_0000);
        check("redirected_addr", imem_addr, 32'h0040_0000);
        check("redirected_req", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        check("jump_fetch_pc", pc, 32'h0040_0004);
        tick();
        mpc = 32'h0040_0004;

        // Redirect during DONE is held, then overwritten by a later one, then cleared
        do_fetch(32'hAAAA_0001, 0, 4, 32'h0000_0200, 32'h0040_0008);
        check("pending_not_applied", pc, 32'h0040_0008);
        do_fetch(32'hBBBB_0002, 1, 1, 32'h0000_0304, 32'h0000_0304);
        do_fetch(32'hCCCC_0003, 0, 0, 32'h0, 32'h0000_0308);

        // Wrap-around at the top of the address space
        set_redirect(1, 32'hFFFF_FFFF);
        tick();
        clear_redirect();
        check("pc_top", pc, 32'hFFFF_FFFC);
        check("pc_plus4_wrap", pc_plus4, 32'h0);
        mpc = 32'hFFFF_FFFC;
        do_fetch(32'h0000_1234, 1, 0, 32'h0, 32'h0);

        // ack outside REQ is ignored
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_0000;
        tick();
        tick();
        imem_ack = 1'b0;
        check("idle_ack_ir", ir, 32'h0000_1234);
        check("idle_ack_busy", {31'b0, busy}, 32'h0);

        // Reset in the middle of REQ, then a late ack
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("pre_rst_req", {31'b0, imem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_ir", ir, 32'h0);
        check("midrst_opcode", {26'b0, opcode}, 32'h0);
        check("midrst_funct", {26'b0, funct}, 32'h0);
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_ir_valid", {31'b0, ir_valid}, 32'h0);
        tick();
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h5555_5555;
        tick();
        tick();
        imem_ack = 1'b0;
        check("late_ack_ir", ir, 32'h0);
        check("late_ack_busy", {31'b0, busy}, 32'h0);

        // Timeout: four REQ cycles without ack, then sticky fault
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_req_held", {31'b0, imem_req}, 32'h1);
            check("to_addr", imem_addr, 32'h0);
            tick();
        end
        check("to_req_drop", {31'b0, imem_req}, 32'h0);
        check("to_fault", {31'b0, fault}, 32'h1);
        check("to_pc", pc, 32'h0);
        check("to_busy", {31'b0, busy}, 32'h0);
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fault_blocks_fetch", {31'b0, imem_req}, 32'h0);
        end
        fetch_en = 1'b0;
        set_redirect(1, 32'h0000_0040);
        tick();
        clear_redirect();
        check("fault_redirect_pc", pc, 32'h0000_0040);
        check("fault_sticky", {31'b0, fault}, 32'h1);
        rst = 1'b1;
        #1;
        check("fault_clear_rst", {31'b0, fault}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        check("sb_drained", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
